// File: rtl/ibex_pkg.sv
// Shared types for the LSU data interface: access sizes, FSM states and
// small helpers describing how an access maps onto the 32-bit bus.
package ibex_pkg;

   typedef enum logic [1:0] {
      LSU_WORD = 2'b00,
      LSU_HALF = 2'b01,
      LSU_BYTE = 2'b10
   } lsu_type_e;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_GNT_MIS,
      WAIT_RV_MIS,
      WAIT_GNT,
      WAIT_RV
   } lsu_fsm_e;

   function automatic logic [3:0] lsu_base_be(input logic [1:0] lsu_type);
      case (lsu_type_e'(lsu_type))
         LSU_WORD: return 4'b1111;
         LSU_HALF: return 4'b0011;
         default:  return 4'b0001;
      endcase
   endfunction

   // An access splits when its bytes run past the end of the addressed word.
   function automatic logic lsu_is_split(input logic [1:0] lsu_type, input logic [1:0] offset);
      case (lsu_type_e'(lsu_type))
         LSU_WORD: return (offset != 2'b00);
         LSU_HALF: return (offset == 2'b11);
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ibex_lsu_load_align.sv
// Combinational load alignment: picks the addressed bytes out of one or two
// bus words and zero/sign-extends them to 32 bits.
module ibex_lsu_load_align
   import ibex_pkg::*;
(
   input  logic [31:0] rdata_lo_i,
   input  logic [31:0] rdata_hi_i,
   input  logic [1:0]  offset_i,
   input  logic [1:0]  type_i,
   input  logic        sign_ext_i,
   output logic [31:0] rdata_o
);

   logic [31:0] shifted;

   always_comb begin
      shifted = 32'({rdata_hi_i, rdata_lo_i} >> {offset_i, 3'b000});
      case (lsu_type_e'(type_i))
         LSU_WORD: rdata_o = shifted;
         LSU_HALF: rdata_o = {{16{sign_ext_i & shifted[15]}}, shifted[15:0]};
         default:  rdata_o = {{24{sign_ext_i & shifted[7]}}, shifted[7:0]};
      endcase
   end

endmodule

// File: rtl/ibex_lsu_data_if.sv
// Data-side bus initiator: issues one or two aligned word transactions per
// load/store and returns aligned, extended load data with a single valid pulse.
module ibex_lsu_data_if
   import ibex_pkg::*;
#(
   parameter bit WritebackStage = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_ni,

   input  logic        lsu_req_i,
   input  logic        lsu_we_i,
   input  logic [1:0]  lsu_type_i,
   input  logic        lsu_sign_ext_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_wdata_i,
   output logic        lsu_req_done_o,
   output logic        lsu_busy_o,

   output logic        data_req_o,
   input  logic        data_gnt_i,
   input  logic        data_rvalid_i,
   input  logic        data_err_i,
   input  logic [31:0] data_rdata_i,
   output logic [31:0] data_addr_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_wdata_o,

   output logic        lsu_data_valid_o,
   output logic [31:0] lsu_rdata_o,
   output logic        lsu_err_o
);

   lsu_fsm_e    state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  type_q, type_d;
   logic        sign_q, sign_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        split_q, split_d;
   logic [31:0] rdata_first_q, rdata_first_d;
   logic        err_first_q, err_first_d;
   logic [31:0] lsu_rdata_q, lsu_rdata_d;
   logic        lsu_err_q, lsu_err_d;
   logic        data_valid_q, data_valid_d;

   logic        accept, split_cur, second_half, final_gnt, final_rvalid;
   logic        cur_we;
   logic [1:0]  cur_type, cur_off;
   logic [31:0] cur_addr, cur_wdata;
   logic [7:0]  be_wide;
   logic [31:0] align_lo, align_hi, load_data;

   // With no writeback stage, ID/EX still holds its request during the
   // done pulse, so that cycle must not start a new access.
   assign accept = rst_ni & lsu_req_i & (state_q == IDLE) &
                   ~(~WritebackStage & data_valid_q);

   // In IDLE the bus is driven straight from ID/EX so the request goes out
   // in the capture cycle; afterwards the captured copy keeps it stable.
   assign cur_we    = (state_q == IDLE) ? lsu_we_i    : we_q;
   assign cur_type  = (state_q == IDLE) ? lsu_type_i  : type_q;
   assign cur_addr  = (state_q == IDLE) ? lsu_addr_i  : addr_q;
   assign cur_wdata = (state_q == IDLE) ? lsu_wdata_i : wdata_q;
   assign cur_off   = cur_addr[1:0];
   assign split_cur = (state_q == IDLE) ? lsu_is_split(lsu_type_i, lsu_addr_i[1:0]) : split_q;

   assign second_half = (state_q == WAIT_RV_MIS) || ((state_q == WAIT_GNT) && split_q);

   assign be_wide      = {4'b0000, lsu_base_be(cur_type)} << cur_off;
   assign data_be_o    = second_half ? be_wide[7:4] : be_wide[3:0];
   assign data_addr_o  = {cur_addr[31:2], 2'b00} + (second_half ? 32'd4 : 32'd0);
   assign data_we_o    = cur_we;
   assign data_wdata_o = 32'({cur_wdata, cur_wdata} >> (6'd32 - {1'b0, cur_off, 3'b000}));

   always_comb begin
      case (state_q)
         IDLE:                   data_req_o = accept;
         WAIT_GNT_MIS, WAIT_GNT: data_req_o = 1'b1;
         WAIT_RV_MIS:            data_req_o = data_rvalid_i;
         default:                data_req_o = 1'b0;
      endcase
   end

   assign final_gnt    = data_req_o & data_gnt_i &
                         ((state_q == IDLE) ? ~split_cur : (state_q != WAIT_GNT_MIS));
   assign final_rvalid = (state_q == WAIT_RV) & data_rvalid_i;

   assign align_lo = split_q ? rdata_first_q : data_rdata_i;
   assign align_hi = split_q ? data_rdata_i  : 32'd0;

   ibex_lsu_load_align u_load_align (
      .rdata_lo_i (align_lo),
      .rdata_hi_i (align_hi),
      .offset_i   (addr_q[1:0]),
      .type_i     (type_q),
      .sign_ext_i (sign_q),
      .rdata_o    (load_data)
   );

   always_comb begin
      state_d       = state_q;
      we_d          = we_q;
      type_d        = type_q;
      sign_d        = sign_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      split_d       = split_q;
      rdata_first_d = rdata_first_q;
      err_first_d   = err_first_q;
      lsu_rdata_d   = lsu_rdata_q;
      lsu_err_d     = lsu_err_q;
      data_valid_d  = final_rvalid;

      case (state_q)
         IDLE: begin
            if (accept) begin
               we_d          = lsu_we_i;
               type_d        = lsu_type_i;
               sign_d        = lsu_sign_ext_i;
               addr_d        = lsu_addr_i;
               wdata_d       = lsu_wdata_i;
               split_d       = split_cur;
               rdata_first_d = 32'd0;
               err_first_d   = 1'b0;
               if (data_gnt_i) state_d = split_cur ? WAIT_RV_MIS  : WAIT_RV;
               else            state_d = split_cur ? WAIT_GNT_MIS : WAIT_GNT;
            end
         end
         WAIT_GNT_MIS: if (data_gnt_i) state_d = WAIT_RV_MIS;
         WAIT_RV_MIS: begin
            if (data_rvalid_i) begin
               rdata_first_d = data_rdata_i;
               err_first_d   = data_err_i;
               state_d       = data_gnt_i ? WAIT_RV : WAIT_GNT;
            end
         end
         WAIT_GNT: if (data_gnt_i) state_d = WAIT_RV;
         WAIT_RV: begin
            if (data_rvalid_i) begin
               state_d   = IDLE;
               lsu_err_d = err_first_q | data_err_i;
               if (!we_q) lsu_rdata_d = load_data;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         we_q          <= 1'b0;
         type_q        <= 2'b00;
         sign_q        <= 1'b0;
         addr_q        <= 32'd0;
         wdata_q       <= 32'd0;
         split_q       <= 1'b0;
         rdata_first_q <= 32'd0;
         err_first_q   <= 1'b0;
         lsu_rdata_q   <= 32'd0;
         lsu_err_q     <= 1'b0;
         data_valid_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         we_q          <= we_d;
         type_q        <= type_d;
         sign_q        <= sign_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         split_q       <= split_d;
         rdata_first_q <= rdata_first_d;
         err_first_q   <= err_first_d;
         lsu_rdata_q   <= lsu_rdata_d;
         lsu_err_q     <= lsu_err_d;
         data_valid_q  <= data_valid_d;
      end
   end

   assign lsu_busy_o       = (state_q != IDLE);
   assign lsu_data_valid_o = data_valid_q;
   assign lsu_rdata_o      = lsu_rdata_q;
   assign lsu_err_o        = lsu_err_q;
   assign lsu_req_done_o   = WritebackStage ? final_gnt : data_valid_q;

   // A response is only legal while a transaction is outstanding.
   rvalid_only_when_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
      data_rvalid_i |-> (state_q == WAIT_RV_MIS || state_q == WAIT_RV));

endmodule
